vram_arbiter: RTL

Owns the external 128K×8 video SRAM and shares it between two requesters: the scanline fetcher (reads) and the MCU pixel-write path (writes). MCU writes are buffered in a small FIFO so the MCU never stalls during display fetches. A fixed-timing state machine drives the SRAM strobes. The block sits between the video/MCU front ends and the top-level SRAM pins; the top level owns the tristate buffer.

---
 rtl/vram_pkg.sv | 10 +
 rtl/vram_write_fifo.sv | 36 +++
 rtl/vram_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared default widths, arbiter state encoding and write-buffer entry type
package vram_pkg;
  localparam int VRAM_ADDR_WIDTH = 17;
  localparam int VRAM_DATA_WIDTH = 8;
  typedef enum logic [2:0] {IDLE, READ, WRITE, HOLD, DONE} state_t;
  typedef struct packed {
    logic [VRAM_ADDR_WIDTH-1:0] addr;
    logic [VRAM_DATA_WIDTH-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/vram_write_fifo.sv
// vram_write_fifo: circular buffer of pending MCU pixel writes
module vram_write_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  fifo_entry_t              push_entry,
  output fifo_entry_t              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  fifo_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push;
  // fullness is judged on the pre-pop count, so a push while full is dropped
  assign do_push = push && count != (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= push_entry;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(pop);
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the video SRAM between scanline reads and buffered MCU writes
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH   = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = VRAM_DATA_WIDTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  videoReadRequest,
  input  logic [ADDR_WIDTH-1:0] videoAddress,
  output logic [DATA_WIDTH-1:0] videoData,
  output logic                  videoReadComplete,
  input  logic                  writeRequest,
  input  logic [ADDR_WIDTH-1:0] writeAddress,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic                  writeReady,
  output logic                  writeOverflow,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  output logic [DATA_WIDTH-1:0] ramDataOut,
  output logic                  ramDataOutEnable,
  input  logic [DATA_WIDTH-1:0] ramDataIn,
  output logic                  ramWriteEnable,
  output logic                  ramOutputEnable
);
  localparam int CW = $clog2(READ_CYCLES > WRITE_CYCLES ? READ_CYCLES : WRITE_CYCLES) + 1;
  localparam logic [CW-1:0] READ_LAST = CW'(READ_CYCLES - 1);
  localparam logic [CW-1:0] WRITE_LAST = CW'(WRITE_CYCLES - 1);
  state_t state, state_next;
  logic [CW-1:0] beat;
  logic last_read, go_read, go_write, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  fifo_entry_t push_entry, head;
  assign push_entry = '{addr: writeAddress, data: writeData};
  vram_write_fifo #(.DEPTH(FIFO_DEPTH)) write_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (writeRequest),
    .pop        (go_write),
    .push_entry (push_entry),
    .head       (head),
    .count      (fifo_count),
    .empty      (fifo_empty)
  );
  assign writeReady = fifo_count != ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH);
  // after a read, a queued write gets the next slot so neither side starves
  assign go_read = state == IDLE && videoReadRequest && (!last_read || fifo_empty);
  assign go_write = state == IDLE && !go_read && !fifo_empty;
  always_comb begin
    state_next = state;
    state_next = go_read ? READ :
                 go_write ? WRITE :
                 (state == READ && beat == READ_LAST) ? DONE :
                 (state == WRITE && beat == WRITE_LAST) ? HOLD :
                 (state == HOLD || state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      beat <= '0;
      last_read <= 1'b0;
      ramAddress <= '0;
      ramDataOut <= '0;
      videoData <= '0;
      writeOverflow <= 1'b0;
    end else begin
      state <= state_next;
      beat <= state_next == state ? beat + CW'(1) : '0;
      if (go_read) begin
        last_read <= 1'b1;
        ramAddress <= videoAddress;
      end
      if (go_write) begin
        last_read <= 1'b0;
        ramAddress <= head.addr;
        ramDataOut <= head.data;
      end
      if (state == READ && state_next == DONE) videoData <= ramDataIn;
      if (writeRequest && !writeReady) writeOverflow <= 1'b1;
    end
  // strobes decode straight from state so reset releases them asynchronously
  assign ramOutputEnable = state != READ;
  assign ramWriteEnable = state != WRITE;
  assign ramDataOutEnable = state == WRITE || state == HOLD;
  assign videoReadComplete = state == DONE;
endmodule
